// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Valid/ready front end for the 8-bit ALU; runs narrow ops in one
//               pass and 16-bit ADD/AND/OR/XOR as two back-to-back passes.
//               Optional perf counters enabled by macro ALU_SEQ_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_wide,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [7:0]  req_shamt,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_zero,
    output logic        resp_carry,
    output logic        resp_err,
    output logic        alu_enable,
    output logic [3:0]  alu_opcode,
    output logic [7:0]  alu_in_a,
    output logic [7:0]  alu_in_b,
    output logic [7:0]  alu_shamp,
    input  logic [7:0]  alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0] perf_ops,
    output logic [7:0]  perf_errs
`endif
);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_ADC = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd5;
    localparam logic [3:0] c_OP_OR  = 4'd6;
    localparam logic [3:0] c_OP_XOR = 4'd7;
    localparam logic [3:0] c_OP_MAX = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE_LO = 3'd1,
        S_CAP_LO   = 3'd2,
        S_ISSUE_HI = 3'd3,
        S_CAP_HI   = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t      state_q;
    logic [3:0]  op_q;
    logic        wide_q;
    logic [7:0]  a_hi_q;
    logic [7:0]  b_hi_q;
    logic        zlo_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic [15:0] resp_data_q;
    logic        resp_zero_q;
    logic        resp_carry_q;
    logic        resp_err_q;
    logic        alu_enable_q;
    logic [3:0]  alu_opcode_q;
    logic [7:0]  alu_in_a_q;
    logic [7:0]  alu_in_b_q;
    logic [7:0]  alu_shamp_q;

    logic        w_wide_legal;
    logic        w_illegal;
    logic [3:0]  w_hi_opcode;

    // Only the bitwise ops and ADD have a meaningful two-pass 16-bit form.
    assign w_wide_legal = (req_op == c_OP_ADD) || (req_op == c_OP_AND) ||
                          (req_op == c_OP_OR)  || (req_op == c_OP_XOR);
    assign w_illegal    = (req_op > c_OP_MAX) || (req_wide && !w_wide_legal);
    assign w_hi_opcode  = (op_q == c_OP_ADD) ? c_OP_ADC : op_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= 4'd0;
            wide_q       <= 1'b0;
            a_hi_q       <= 8'd0;
            b_hi_q       <= 8'd0;
            zlo_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 16'd0;
            resp_zero_q  <= 1'b0;
            resp_carry_q <= 1'b0;
            resp_err_q   <= 1'b0;
            alu_enable_q <= 1'b0;
            alu_opcode_q <= 4'd0;
            alu_in_a_q   <= 8'd0;
            alu_in_b_q   <= 8'd0;
            alu_shamp_q  <= 8'd0;
        end else begin
            alu_enable_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        wide_q      <= req_wide;
                        a_hi_q      <= req_a[15:8];
                        b_hi_q      <= req_b[15:8];
                        req_ready_q <= 1'b0;
                        if (w_illegal) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= 16'd0;
                            resp_zero_q  <= 1'b0;
                            resp_carry_q <= 1'b0;
                        end else begin
                            state_q      <= S_ISSUE_LO;
                            alu_enable_q <= 1'b1;
                            alu_opcode_q <= req_op;
                            alu_in_a_q   <= req_a[7:0];
                            alu_in_b_q   <= req_b[7:0];
                            alu_shamp_q  <= req_shamt;
                        end
                    end
                end
                S_ISSUE_LO: begin
                    state_q <= S_CAP_LO;
                end
                S_CAP_LO: begin
                    resp_data_q <= {8'h00, alu_result};
                    zlo_q       <= alu_zero;
                    if (wide_q) begin
                        state_q      <= S_ISSUE_HI;
                        alu_enable_q <= 1'b1;
                        alu_opcode_q <= w_hi_opcode;
                        alu_in_a_q   <= a_hi_q;
                        alu_in_b_q   <= b_hi_q;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_zero_q  <= alu_zero;
                        resp_carry_q <= alu_carry;
                    end
                end
                S_ISSUE_HI: begin
                    state_q <= S_CAP_HI;
                end
                S_CAP_HI: begin
                    state_q             <= S_RESP;
                    resp_data_q[15:8]   <= alu_result;
                    resp_zero_q         <= zlo_q & alu_zero;
                    resp_carry_q        <= alu_carry;
                    resp_err_q          <= 1'b0;
                    resp_valid_q        <= 1'b1;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_zero  = resp_zero_q;
    assign resp_carry = resp_carry_q;
    assign resp_err   = resp_err_q;
    assign alu_enable = alu_enable_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_in_a   = alu_in_a_q;
    assign alu_in_b   = alu_in_b_q;
    assign alu_shamp  = alu_shamp_q;

`ifdef ALU_SEQ_PERF_EN
    logic        w_resp_fire;
    logic [15:0] perf_ops_q;
    logic [7:0]  perf_errs_q;

    assign w_resp_fire = resp_valid_q & resp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops_q  <= 16'd0;
            perf_errs_q <= 8'd0;
        end else if (w_resp_fire) begin
            if (resp_err_q) begin
                if (perf_errs_q != 8'hFF) perf_errs_q <= perf_errs_q + 8'd1;
            end else begin
                if (perf_ops_q != 16'hFFFF) perf_ops_q <= perf_ops_q + 16'd1;
            end
        end
    end

    assign perf_ops  = perf_ops_q;
    assign perf_errs = perf_errs_q;
`else
    // Counters absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer with a small
//               behavioural 8-bit ALU (one-cycle registered latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic        req_wide = 1'b0;
    logic [15:0] req_a = 16'd0;
    logic [15:0] req_b = 16'd0;
    logic [7:0]  req_shamt = 8'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic        resp_zero;
    logic        resp_carry;
    logic        resp_err;
    logic        alu_enable;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_in_a;
    logic [7:0]  alu_in_b;
    logic [7:0]  alu_shamp;
    logic [7:0]  alu_result = 8'd0;
    logic        alu_zero;
    logic        alu_carry = 1'b0;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_ops;
    logic [7:0]  perf_errs;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_wide   (req_wide),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shamt  (req_shamt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_carry (resp_carry),
        .resp_err   (resp_err),
        .alu_enable (alu_enable),
        .alu_opcode (alu_opcode),
        .alu_in_a   (alu_in_a),
        .alu_in_b   (alu_in_b),
        .alu_shamp  (alu_shamp),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry)
`ifdef ALU_SEQ_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_errs  (perf_errs)
`endif
    );

    // Behavioural ALU: registered result/carry, carry untouched by logic/shift ops.
    assign alu_zero = (alu_result == 8'd0);
    always @(posedge clk) begin
        if (alu_enable) begin
            case (alu_opcode)
                4'd0: {alu_carry, alu_result} <= {1'b0, alu_in_a} + {1'b0, alu_in_b};
                4'd1: {alu_carry, alu_result} <= {1'b0, alu_in_a} + {1'b0, alu_in_b} + {8'd0, alu_carry};
                4'd2: {alu_carry, alu_result} <= {1'b0, alu_in_a} - {1'b0, alu_in_b};
                4'd3: {alu_carry, alu_result} <= {1'b0, alu_in_a} + {1'b0, alu_shamp};
                4'd4: {alu_carry, alu_result} <= {1'b0, alu_in_a} - {1'b0, alu_shamp};
                4'd5: alu_result <= alu_in_a & alu_in_b;
                4'd6: alu_result <= alu_in_a | alu_in_b;
                4'd7: alu_result <= alu_in_a ^ alu_in_b;
                4'd8: alu_result <= alu_in_a >> alu_shamp;
                4'd9: alu_result <= alu_in_a << alu_shamp;
                default: ;
            endcase
        end
    end

    // Presents one request, returns latency (accept edge counts as 1) and
    // the ALU enable pulses seen; lat = -1 if no response within the budget.
    task automatic issue(input logic [3:0] op, input logic wide,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] sh, output int lat, output int npulse,
                         output logic [3:0] opc0, output logic [3:0] opc1);
        req_op = op; req_wide = wide; req_a = a; req_b = b; req_shamt = sh;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; npulse = 0; opc0 = 4'hF; opc1 = 4'hF;
        for (int k = 0; k < 20; k++) begin
            if (alu_enable) begin
                if (npulse == 0) opc0 = alu_opcode;
                else             opc1 = alu_opcode;
                npulse++;
            end
            if (resp_valid) begin
                lat = k + 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (alu_enable !== 1'b0) begin n_fail++; $display("FAIL reset_alu_enable: got %b want 0", alu_enable); end
        n_cmp++; if ({resp_data, resp_zero, resp_carry, resp_err} !== 19'd0) begin n_fail++; $display("FAIL reset_resp: got %h want 0", {resp_data, resp_zero, resp_carry, resp_err}); end
        n_cmp++; if ({alu_opcode, alu_in_a, alu_in_b, alu_shamp} !== 28'd0) begin n_fail++; $display("FAIL reset_alu_outs: got %h want 0", {alu_opcode, alu_in_a, alu_in_b, alu_shamp}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_narrow_add();
        int lat, np; logic [3:0] o0, o1;
        issue(4'd0, 1'b0, 16'h000F, 16'h0001, 8'd0, lat, np, o0, o1);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL nadd_latency: got %0d want 3", lat); end
        n_cmp++; if (np !== 1) begin n_fail++; $display("FAIL nadd_pulses: got %0d want 1", np); end
        n_cmp++; if (o0 !== 4'd0) begin n_fail++; $display("FAIL nadd_opcode: got %0d want 0", o0); end
        n_cmp++; if (resp_data !== 16'h0010) begin n_fail++; $display("FAIL nadd_data: got %h want 0010", resp_data); end
        n_cmp++; if ({resp_zero, resp_carry, resp_err} !== 3'b000) begin n_fail++; $display("FAIL nadd_flags: got %b want 000", {resp_zero, resp_carry, resp_err}); end
        drain();
        n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL nadd_release: got %b want 01", {resp_valid, req_ready}); end
    endtask

    task automatic test_wide_add();
        int lat, np; logic [3:0] o0, o1;
        issue(4'd0, 1'b1, 16'h00FF, 16'h0001, 8'd0, lat, np, o0, o1);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL wadd_latency: got %0d want 5", lat); end
        n_cmp++; if (np !== 2) begin n_fail++; $display("FAIL wadd_pulses: got %0d want 2", np); end
        n_cmp++; if ({o0, o1} !== 8'h01) begin n_fail++; $display("FAIL wadd_opcodes: got %h want 01", {o0, o1}); end
        n_cmp++; if (resp_data !== 16'h0100) begin n_fail++; $display("FAIL wadd_data: got %h want 0100", resp_data); end
        n_cmp++; if ({resp_zero, resp_carry, resp_err} !== 3'b000) begin n_fail++; $display("FAIL wadd_flags: got %b want 000", {resp_zero, resp_carry, resp_err}); end
        drain();
    endtask

    task automatic test_wide_xor();
        int lat, np; logic [3:0] o0, o1;
        issue(4'd7, 1'b1, 16'h1234, 16'h1234, 8'd0, lat, np, o0, o1);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL wxor_latency: got %0d want 5", lat); end
        n_cmp++; if ({o0, o1} !== 8'h77) begin n_fail++; $display("FAIL wxor_opcodes: got %h want 77", {o0, o1}); end
        n_cmp++; if (resp_data !== 16'h0000) begin n_fail++; $display("FAIL wxor_data: got %h want 0000", resp_data); end
        n_cmp++; if ({resp_zero, resp_carry, resp_err} !== 3'b100) begin n_fail++; $display("FAIL wxor_flags: got %b want 100", {resp_zero, resp_carry, resp_err}); end
        drain();
        // Only the high byte is zero: whole-word zero flag must be clear.
        issue(4'd6, 1'b1, 16'h0001, 16'h0000, 8'd0, lat, np, o0, o1);
        n_cmp++; if ({resp_data, resp_zero} !== {16'h0001, 1'b0}) begin n_fail++; $display("FAIL wor_data_zero: got %h/%b want 0001/0", resp_data, resp_zero); end
        drain();
    endtask

    task automatic test_illegal();
        int lat, np; logic [3:0] o0, o1;
        issue(4'd12, 1'b0, 16'h00AA, 16'h0055, 8'd0, lat, np, o0, o1);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ill_op_latency: got %0d want 1", lat); end
        n_cmp++; if (np !== 0) begin n_fail++; $display("FAIL ill_op_pulses: got %0d want 0", np); end
        n_cmp++; if ({resp_err, resp_data, resp_zero, resp_carry} !== {1'b1, 18'd0}) begin n_fail++; $display("FAIL ill_op_resp: got %h want 40000", {resp_err, resp_data, resp_zero, resp_carry}); end
        drain();
        issue(4'd2, 1'b1, 16'h0009, 16'h0003, 8'd0, lat, np, o0, o1);
        n_cmp++; if ({lat == 1, resp_err} !== 2'b11) begin n_fail++; $display("FAIL ill_wide_sub: got lat=%0d err=%b want lat=1 err=1", lat, resp_err); end
        n_cmp++; if (np !== 0) begin n_fail++; $display("FAIL ill_wide_pulses: got %0d want 0", np); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat, np; logic [3:0] o0, o1;
        issue(4'd0, 1'b0, 16'h0080, 16'h0080, 8'd0, lat, np, o0, o1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if ({resp_valid, req_ready, resp_data} !== {2'b10, 16'h0000}) begin n_fail++; $display("FAIL bp_hold%0d: got %b/%b/%h want 1/0/0000", i, resp_valid, req_ready, resp_data); end
        end
        n_cmp++; if ({resp_zero, resp_carry} !== 2'b11) begin n_fail++; $display("FAIL bp_flags: got %b want 11", {resp_zero, resp_carry}); end
        drain();
        n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b want 01", {resp_valid, req_ready}); end
        // Narrow ADC picks up the carry left by the previous ALU op: 1+1+1.
        issue(4'd1, 1'b0, 16'h0001, 16'h0001, 8'd0, lat, np, o0, o1);
        n_cmp++; if ({resp_data, resp_carry} !== {16'h0003, 1'b0}) begin n_fail++; $display("FAIL adc_chain: got %h/%b want 0003/0", resp_data, resp_carry); end
        drain();
    endtask

    task automatic test_reset_midop();
        int lat, np; logic [3:0] o0, o1;
        req_op = 4'd0; req_wide = 1'b1; req_a = 16'h1111; req_b = 16'h2222;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({alu_enable, alu_opcode} !== 5'h11) begin n_fail++; $display("FAIL mid_issue_hi: got %h want 11", {alu_enable, alu_opcode}); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if ({alu_enable, resp_valid, req_ready} !== 3'b001) begin n_fail++; $display("FAIL mid_reset: got %b want 001", {alu_enable, resp_valid, req_ready}); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_resp: got %b want 0", resp_valid); end
        issue(4'd2, 1'b0, 16'h0005, 16'h0005, 8'd0, lat, np, o0, o1);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sub_latency: got %0d want 3", lat); end
        n_cmp++; if ({resp_data, resp_zero, resp_err} !== {16'h0000, 2'b10}) begin n_fail++; $display("FAIL sub_result: got %h/%b/%b want 0000/1/0", resp_data, resp_zero, resp_err); end
        drain();
    endtask

    initial begin
        test_reset();
        test_narrow_add();
        test_wide_add();
        test_wide_xor();
        test_illegal();
        test_backpressure();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Front-end controller for the 8-bit ALU.
- Accepts one operation at a time from a requester over a valid/ready interface, drives the ALU control and operand inputs, waits out the ALU's registered latency, captures result and flags, and returns them over a valid/ready response channel.
- Also sequences 16-bit ADD/AND/OR/XOR as two back-to-back ALU passes. 16-bit ADD is ADD on the low byte, then ADC on the high byte.

Parameters:
- none (widths fixed by the 8-bit datapath)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  4  ALU opcode: 0 ADD, 1 ADC, 2 SUB, 3 ADDI, 4 SUBI, 5 AND, 6 OR, 7 XOR, 8 SHR, 9 SHL
- req_wide  in  1  1 = 16-bit operation
- req_a  in  16  operand A (narrow ops use [7:0])
- req_b  in  16  operand B (narrow ops use [7:0])
- req_shamt  in  8  immediate / shift amount, passed to the ALU shamp input
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_data  out  16  result (narrow: [15:8]=0)
- resp_zero  out  1  result == 0 (wide: whole 16 bits)
- resp_carry  out  1  ALU carry after the final pass
- resp_err  out  1  illegal request; data/flags zero
- alu_enable  out  1  to ALU enable_alu
- alu_opcode  out  4  to ALU opcode
- alu_in_a  out  8  to ALU in_a
- alu_in_b  out  8  to ALU in_b
- alu_shamp  out  8  to ALU shamp
- alu_result  in  8  from ALU alu_out
- alu_zero  in  1  from ALU flag_zero
- alu_carry  in  1  from ALU flag_carry

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, except req_ready, which is 1 in IDLE.
  - Reset mid-operation abandons the operation; no response is produced.
  - alu_enable is 0 from the first reset edge.
- FSM states: IDLE, ISSUE_LO, CAP_LO, ISSUE_HI, CAP_HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, the request is latched.
  - Legal request: next state is ISSUE_LO.
  - Illegal request: next state is RESP with resp_err=1. Illegal means req_op>9, or req_wide=1 with req_op not in {0,5,6,7}.
- ISSUE_LO:
  - alu_enable=1 for exactly this cycle.
  - alu_opcode=req_op, alu_in_a=a[7:0], alu_in_b=b[7:0], alu_shamp=shamt.
  - Next state is CAP_LO.
- CAP_LO:
  - Capture alu_result into data[7:0] and alu_zero into zlo.
  - Narrow: next state is RESP; resp_carry = alu_carry, resp_zero = alu_zero.
  - Wide: next state is ISSUE_HI.
- ISSUE_HI:
  - alu_enable=1; operands are a[15:8] and b[15:8].
  - alu_opcode = ADC if the op is ADD, otherwise the same op.
  - Next state is CAP_HI.
- CAP_HI:
  - Capture data[15:8].
  - resp_zero = zlo & alu_zero; resp_carry = alu_carry.
  - Next state is RESP.
- RESP:
  - resp_valid=1; data and flags are held stable until resp_ready=1.
  - On that edge, the next state is IDLE. No back-to-back accept in the same cycle.
- Operand and opcode outputs hold their last driven values outside the ISSUE states. Only alu_enable gates the ALU.
- Latency from accept edge to resp_valid high:
  - narrow: 3 cycles
  - wide: 5 cycles
  - error: 1 cycle
- Narrow ADC uses the ALU's carry left by the previous ALU operation. It is not reset by this block.
- Logical ops: resp_carry reports the ALU's held carry. The ALU does not update carry for logical ops.
- Throughput: at most one request in flight; req_ready=0 in every state except IDLE.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- When defined:
  - Extra output perf_ops (16-bit) counts completed non-error responses (resp_valid & resp_ready & ~resp_err).
  - Extra output perf_errs (8-bit) counts error responses.
  - Both counters saturate at all-ones and clear on reset.
- When undefined: neither port nor counter logic exists; behaviour is otherwise identical.

Test Plan:
- Reset then narrow ADD a=0x0F, b=0x01:
  - alu_enable pulses once, 1 cycle after accept.
  - resp_valid 3 cycles after accept.
  - resp_data=0x0010, resp_zero=0, resp_carry=0.
- Wide ADD a=0x00FF, b=0x0001:
  - Two alu_enable pulses; opcodes 0 then 1.
  - resp_data=0x0100, resp_zero=0, resp_carry=0.
  - resp_valid at 5 cycles.
- Wide XOR a=0x1234, b=0x1234: resp_data=0x0000, resp_zero=1.
- Illegal requests:
  - req_op=12: resp_err=1 after 1 cycle, alu_enable never asserted.
  - req_wide=1 with SUB: resp_err=1.
- Backpressure: hold resp_ready=0 for 4 cycles after resp_valid.
  - resp_valid and resp_data remain stable.
  - req_ready stays 0.
  - IDLE is entered only on the resp_ready edge.
- Reset mid-op: assert rst_n=0 during ISSUE_HI of a wide ADD.
  - Next cycle: IDLE, alu_enable=0, no resp_valid.
  - A following narrow SUB 0x05-0x05 returns resp_data=0, resp_zero=1.
